picorv_pcpi_mul: RTL and testbench
==================================

PICORV_PCPI_MUL -- requirements
Module: picorv_pcpi_mul

Interface
REQ-001 SHALL have parameter XLEN, default 32, the datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter ILEN, default 32, the instruction width presented on pcpi_insn.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port pcpi_valid  input  1  the core offers an instruction; held until pcpi_ready or withdrawn.
REQ-006 SHALL have port pcpi_insn  input  ILEN  the offered instruction word.
REQ-007 SHALL have port pcpi_rs1_data  input  XLEN  the rs1 operand.
REQ-008 SHALL have port pcpi_rs2_data  input  XLEN  the rs2 operand.
REQ-009 SHALL have port pcpi_ready  output  1  a one-cycle completion pulse.
REQ-010 SHALL have port pcpi_wb_write  output  1  the writeback request, valid with pcpi_ready.
REQ-011 SHALL have port pcpi_wb_data  output  XLEN  the rd result, valid with pcpi_ready.
REQ-012 SHALL have port pcpi_br_enable  output  1  the branch request, constant 0.
REQ-013 SHALL have port pcpi_br_nextpc  output  XLEN  the branch target, constant 0.
REQ-014 SHALL have port busy  output  1  high while in state CALC or DONE.

Function
REQ-015 SHALL decode an instruction as accepted when opcode[6:0]=0110011, funct7[31:25]=0000001 and funct3[14:12] is 000 (MUL), 001 (MULH), 010 (MULHSU) or 011 (MULHU).
REQ-016 SHALL leave every other instruction unanswered: no pcpi_ready, no state change.
REQ-017 SHALL implement the states IDLE, CALC, DONE and GUARD.
REQ-018 In IDLE with pcpi_valid=1 and an accepted instruction, SHALL latch the operands and funct3, clear the iteration counter, and go to CALC.
REQ-019 CALC SHALL last exactly XLEN cycles, counted by a counter of width clog2(XLEN)+1, then go to DONE.
REQ-020 DONE SHALL last one cycle with pcpi_ready=1 and pcpi_wb_write=1, then go to GUARD.
REQ-021 GUARD SHALL last one cycle, ignore pcpi_valid, and return to IDLE.
REQ-022 pcpi_ready SHALL rise exactly XLEN+1 cycles after the accepting IDLE cycle.
REQ-023 Result arithmetic: rs1 SHALL be sign-extended to 2*XLEN for MULH and MULHSU, and zero-extended otherwise.
REQ-024 Result arithmetic: rs2 SHALL be sign-extended to 2*XLEN for MULH only, and zero-extended otherwise.
REQ-025 Result arithmetic: the product SHALL be taken mod 2^(2*XLEN); MUL returns bits [XLEN-1:0] and the others return bits [2*XLEN-1:XLEN].
REQ-026 The internal algorithm (shift-add, or magnitude-multiply then conditional negate) is free, provided the latency of REQ-022 holds.
REQ-027 pcpi_wb_data SHALL be 0 in every cycle where pcpi_ready=0.
REQ-028 pcpi_wb_write SHALL be 0 in every cycle where pcpi_ready=0.
REQ-029 If pcpi_valid=0 in any CALC cycle, SHALL abort: go to IDLE next cycle, never assert pcpi_ready for that instruction, and leave no side effects.
REQ-030 If pcpi_valid=0 during DONE, SHALL still complete the pulse; the core discards it.
REQ-031 Operand or insn changes while in CALC SHALL NOT affect the result; only latched values are used.
REQ-032 A new accepted instruction SHALL be taken in IDLE, at the earliest XLEN+3 cycles after the previous accept (back-to-back throughput).
REQ-033 pcpi_br_enable and pcpi_br_nextpc SHALL be constant 0 in all cycles.

Reset
REQ-034 resetn=0 at a clock edge SHALL force state IDLE, counter 0, pcpi_ready=0, pcpi_wb_write=0, pcpi_wb_data=0 and busy=0 from the next cycle, in any state.
REQ-035 Latched operand and accumulator registers need no reset, but SHALL never be visible on pcpi_wb_data outside DONE.
REQ-036 Reset asserted mid-CALC SHALL discard the operation with no subsequent ready pulse.
REQ-037 pcpi_valid SHALL be ignored in the cycle resetn=0, and accepted from the first cycle with resetn=1.

Verification
REQ-038 XLEN=32, MUL, rs1=7, rs2=6, valid held -> ready exactly 33 cycles after accept, wb_write=1, wb_data=0x0000002A, then busy=0 two cycles later.
REQ-039 rs1=rs2=0xFFFFFFFF -> MULH=0x00000000, MULHU=0xFFFFFFFE, MULHSU=0xFFFFFFFF, MUL=0x00000001.
REQ-040 MULH, rs1=rs2=0x80000000 -> wb_data=0x40000000; MULHSU, rs1=0x80000000, rs2=0x00000002 -> 0xFFFFFFFF.
REQ-041 ADD insn (funct7=0000000) with valid held 40 cycles -> pcpi_ready stays 0, busy stays 0.
REQ-042 MUL accepted, valid dropped in CALC cycle 10, then MUL rs1=3, rs2=5 issued -> no ready for the first operation, second operation returns 0x0000000F with 33-cycle latency.
REQ-043 resetn=0 for one cycle during CALC cycle 20, valid held -> no ready pulse; the instruction is re-accepted after reset and completes normally.

Source files
------------

// File: rtl/picorv_pcpi_mul.sv
`default_nettype none
// ============================================================================
//  Module      : picorv_pcpi_mul
//  Description : Iterative PCPI multiplier for the RV M-extension MUL, MULH,
//                MULHSU and MULHU instructions. It forms the magnitude product
//                by shift-add (one multiplier bit per cycle, XLEN cycles) and
//                negates the result when the operand signs differ.
//  Revision    : 1.0 - initial release
// ============================================================================
module picorv_pcpi_mul #(
  parameter int XLEN = 32,
  parameter int ILEN = 32   // must be at least 32; only bits [31:0] are decoded
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [ILEN-1:0] pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1_data,
  input  logic [XLEN-1:0] pcpi_rs2_data,
  output logic            pcpi_ready,
  output logic            pcpi_wb_write,
  output logic [XLEN-1:0] pcpi_wb_data,
  output logic            pcpi_br_enable,
  output logic [XLEN-1:0] pcpi_br_nextpc,
  output logic            busy
);

  localparam int c_CNT_W = $clog2(XLEN) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_DONE  = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_CNT_W-1:0]  r_cnt;

  // Shift-add datapath: r_ma is the left-shifting multiplicand, r_mb the
  // right-shifting multiplier, r_acc the running magnitude product.
  logic [2*XLEN-1:0]   r_ma;
  logic [XLEN-1:0]     r_mb;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic                r_is_mul;

  logic                w_insn_ok;
  logic                w_accept;
  logic                w_calc_last;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [2*XLEN-1:0]   w_prod;
  logic                w_unused_insn;

  // Decode: OP opcode, funct7 = MULDIV, funct3 in 000..011 (bit 14 clear).
  assign w_insn_ok = (pcpi_insn[6:0] == 7'b0110011) &&
                     (pcpi_insn[31:25] == 7'b0000001) &&
                     (pcpi_insn[14] == 1'b0);
  assign w_accept  = (r_state == S_IDLE) && pcpi_valid && w_insn_ok;

  // rs1 is signed for MULH (001) and MULHSU (010); rs2 only for MULH.
  assign w_a_signed = pcpi_insn[13] ^ pcpi_insn[12];
  assign w_b_signed = ~pcpi_insn[13] & pcpi_insn[12];
  assign w_a_neg    = w_a_signed & pcpi_rs1_data[XLEN-1];
  assign w_b_neg    = w_b_signed & pcpi_rs2_data[XLEN-1];
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign w_a_mag    = w_a_neg ? ({XLEN{1'b0}} - pcpi_rs1_data) : pcpi_rs1_data;
  assign w_b_mag    = w_b_neg ? ({XLEN{1'b0}} - pcpi_rs2_data) : pcpi_rs2_data;

  assign w_calc_last = (r_cnt == c_LAST);
  assign w_prod      = r_neg ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;

  // Register and rd fields are don't-care for this unit.
  assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs; everything else is gated to zero.
  always_comb begin
    w_state_next  = r_state;
    pcpi_ready    = 1'b0;
    pcpi_wb_write = 1'b0;
    pcpi_wb_data  = '0;
    busy          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (!pcpi_valid)      w_state_next = S_IDLE;
        else if (w_calc_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy          = 1'b1;
        pcpi_ready    = 1'b1;
        pcpi_wb_write = 1'b1;
        pcpi_wb_data  = r_is_mul ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        w_state_next  = S_GUARD;
      end
      S_GUARD: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Iteration counter: cleared on accept, advances once per CALC cycle.
  always_ff @(posedge clock) begin
    if (!resetn)                r_cnt <= '0;
    else if (w_accept)          r_cnt <= '0;
    else if (r_state == S_CALC) r_cnt <= r_cnt + 1'b1;
  end

  // Operand latch and shift-add step; never visible outside DONE, so no reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_ma     <= {{XLEN{1'b0}}, w_a_mag};
      r_mb     <= w_b_mag;
      r_acc    <= '0;
      r_neg    <= w_a_neg ^ w_b_neg;
      r_is_mul <= (pcpi_insn[13:12] == 2'b00);
    end else if (r_state == S_CALC) begin
      if (r_mb[0]) r_acc <= r_acc + r_ma;
      r_ma <= r_ma << 1;
      r_mb <= r_mb >> 1;
    end
  end

  assign pcpi_br_enable = 1'b0;
  assign pcpi_br_nextpc = '0;

endmodule
`default_nettype wire

// File: tb/tb_picorv_pcpi_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_picorv_pcpi_mul
//  Description : Directed self-checking bench for picorv_pcpi_mul (XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv_pcpi_mul;

  localparam int c_XLEN = 32;

  logic              clock;
  logic              resetn;
  logic              pcpi_valid;
  logic [31:0]       pcpi_insn;
  logic [c_XLEN-1:0] pcpi_rs1_data;
  logic [c_XLEN-1:0] pcpi_rs2_data;
  logic              pcpi_ready;
  logic              pcpi_wb_write;
  logic [c_XLEN-1:0] pcpi_wb_data;
  logic              pcpi_br_enable;
  logic [c_XLEN-1:0] pcpi_br_nextpc;
  logic              busy;

  int total = 0;
  int bad   = 0;

  picorv_pcpi_mul #(.XLEN(c_XLEN), .ILEN(32)) u_dut (
    .clock          (clock),
    .resetn         (resetn),
    .pcpi_valid     (pcpi_valid),
    .pcpi_insn      (pcpi_insn),
    .pcpi_rs1_data  (pcpi_rs1_data),
    .pcpi_rs2_data  (pcpi_rs2_data),
    .pcpi_ready     (pcpi_ready),
    .pcpi_wb_write  (pcpi_wb_write),
    .pcpi_wb_data   (pcpi_wb_data),
    .pcpi_br_enable (pcpi_br_enable),
    .pcpi_br_nextpc (pcpi_br_nextpc),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Issue one op with valid held, scramble operands during CALC, and check the
  // latency, the result, and the idle behaviour right after the pulse.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int  n;
    bit  got;
    @(negedge clock);
    pcpi_insn     = mk_insn(7'b0000001, f3);
    pcpi_rs1_data = a;
    pcpi_rs2_data = b;
    pcpi_valid    = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clock);
      n++;
      if (pcpi_ready) got = 1'b1;
      else begin
        pcpi_rs1_data = $urandom;
        pcpi_rs2_data = $urandom;
      end
    end
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " wb_write"}, 64'(pcpi_wb_write), 64'd1);
    check({tag, " wb_data"}, 64'(pcpi_wb_data), 64'(exp));
    pcpi_valid = 1'b0;
    @(negedge clock);
    check({tag, " guard ready"}, 64'(pcpi_ready), 64'd0);
    check({tag, " guard wb_data"}, 64'(pcpi_wb_data), 64'd0);
    @(negedge clock);
    check({tag, " busy after"}, 64'(busy), 64'd0);
  endtask

  // Directed stimulus sequence.
  initial begin
    int  n;
    bit  seen_ready;
    bit  seen_busy;

    resetn        = 1'b0;
    pcpi_valid    = 1'b0;
    pcpi_insn     = '0;
    pcpi_rs1_data = '0;
    pcpi_rs2_data = '0;
    repeat (3) @(negedge clock);
    check("reset ready", 64'(pcpi_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset wb_data", 64'(pcpi_wb_data), 64'd0);
    check("reset wb_write", 64'(pcpi_wb_write), 64'd0);
    check("br_enable", 64'(pcpi_br_enable), 64'd0);
    check("br_nextpc", 64'(pcpi_br_nextpc), 64'd0);
    resetn = 1'b1;

    run_op("mul 7x6",   3'b000, 32'd7,        32'd6,        32'h0000002A);
    run_op("mulh -1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_op("mulhu -1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulhsu -1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mul -1",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op("mulh min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulhsu min",3'b010, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);
    run_op("mulh mix",  3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
    run_op("mulhu big", 3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E);

    // ADD must stay unanswered.
    @(negedge clock);
    pcpi_insn     = mk_insn(7'b0000000, 3'b000);
    pcpi_rs1_data = 32'd1;
    pcpi_rs2_data = 32'd2;
    pcpi_valid    = 1'b1;
    seen_ready = 1'b0;
    seen_busy  = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (pcpi_ready) seen_ready = 1'b1;
      if (busy)       seen_busy  = 1'b1;
    end
    pcpi_valid = 1'b0;
    check("add ready", 64'(seen_ready), 64'd0);
    check("add busy", 64'(seen_busy), 64'd0);

    // Abort: drop valid in CALC cycle 10, no pulse may follow.
    @(negedge clock);
    pcpi_insn     = mk_insn(7'b0000001, 3'b000);
    pcpi_rs1_data = 32'd9;
    pcpi_rs2_data = 32'd9;
    pcpi_valid    = 1'b1;
    repeat (10) @(negedge clock);
    check("abort busy mid", 64'(busy), 64'd1);
    pcpi_valid = 1'b0;
    seen_ready = 1'b0;
    @(negedge clock);
    check("abort busy drop", 64'(busy), 64'd0);
    repeat (40) begin
      @(negedge clock);
      if (pcpi_ready) seen_ready = 1'b1;
    end
    check("abort no ready", 64'(seen_ready), 64'd0);
    run_op("mul 3x5", 3'b000, 32'd3, 32'd5, 32'h0000000F);

    // Reset pulse during CALC cycle 20 with valid held.
    @(negedge clock);
    pcpi_insn     = mk_insn(7'b0000001, 3'b000);
    pcpi_rs1_data = 32'd7;
    pcpi_rs2_data = 32'd6;
    pcpi_valid    = 1'b1;
    repeat (20) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("rst busy", 64'(busy), 64'd0);
    check("rst ready", 64'(pcpi_ready), 64'd0);
    resetn = 1'b1;
    n   = 0;
    seen_ready = 1'b0;
    while (!seen_ready && n < 60) begin
      @(negedge clock);
      n++;
      if (pcpi_ready) seen_ready = 1'b1;
    end
    check("rst reaccept latency", 64'(n), 64'd33);
    check("rst reaccept data", 64'(pcpi_wb_data), 64'h2A);
    pcpi_valid = 1'b0;
    @(negedge clock);
    check("final br_enable", 64'(pcpi_br_enable), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
